// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU scheduler: opcode encodings and the FSM state type.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_sched_rr_arb.sv
// Combinational round-robin arbiter: searches from last+1 (mod N) and returns a one-hot grant.
module rr_arb #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant
);

  int          pos;
  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(last) + k;
      if (pos >= N) pos = pos - N;
      idx = W'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_sched.sv
// Shares one external FPU among N_REQ requesters: arbitrate, hold operands for the FPU
// latency, capture the result and pulse it back to the owning requester.
module fpu_sched
  import fpu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FPU_LAT = 2,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW     = (FPU_LAT < 1) ? 1 : $clog2(FPU_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [2*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  output logic [1:0]            fpu_op,
  input  logic [31:0]           fpu_o,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  busy,
  output logic [15:0]           ops_done
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d, owner_q, owner_d, rsp_id_q, rsp_id_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d, rsp_data_q, rsp_data_d;
  logic [1:0]        fpu_op_q, fpu_op_d;
  logic [15:0]       ops_done_q, ops_done_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              hs;
  logic [31:0]       a_arr [N_REQ];
  logic [31:0]       b_arr [N_REQ];
  logic [1:0]        op_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi]  = req_a[gi*32 +: 32];
    assign b_arr[gi]  = req_b[gi*32 +: 32];
    assign op_arr[gi] = req_op[gi*2 +: 2];
  end

  rr_arb #(.N(N_REQ), .W(ID_W)) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = ID_W'(i);
    end
  end

  // Ready is suppressed while reset is held so no handshake is implied during reset.
  assign req_ready = (state_q == ST_IDLE && !reset) ? grant : '0;
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    fpu_a_d    = fpu_a_q;
    fpu_b_d    = fpu_b_q;
    fpu_op_d   = fpu_op_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    ops_done_d = ops_done_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          fpu_a_d  = a_arr[grant_idx];
          fpu_b_d  = b_arr[grant_idx];
          fpu_op_d = op_arr[grant_idx];
          owner_d  = grant_idx;
          last_d   = grant_idx;
          cnt_d    = CW'(FPU_LAT);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Counter reaching zero marks the cycle in which fpu_o is valid.
        if (cnt_q == '0) begin
          rsp_data_d = fpu_o;
          rsp_id_d   = owner_q;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        ops_done_d = ops_done_q + 16'd1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= ID_W'(N_REQ - 1);
      owner_q    <= '0;
      cnt_q      <= '0;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_op_q   <= OP_ADD;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      fpu_a_q    <= fpu_a_d;
      fpu_b_q    <= fpu_b_d;
      fpu_op_q   <= fpu_op_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign fpu_op    = fpu_op_q;
  assign rsp_valid = (state_q == ST_RESP) && !reset;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_fpu_sched.sv
// Directed bench for fpu_sched with a 2-stage stand-in FPU that knows two IEEE vectors.
module tb_fpu_sched;
  import fpu_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [7:0]   req_op;
  logic [127:0] req_a, req_b;
  logic [31:0]  fpu_a, fpu_b, fpu_o, rsp_data;
  logic [1:0]   fpu_op, rsp_id;
  logic         rsp_valid, busy;
  logic [15:0]  ops_done;
  logic [31:0]  p0, p1;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  fpu_sched #(.N_REQ(4), .FPU_LAT(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_op(fpu_op), .fpu_o(fpu_o), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fake_fpu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == OP_MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
  endfunction

  // Stand-in FPU: result appears FPU_LAT=2 cycles after operands become stable.
  always @(posedge clk) begin
    p0 <= fake_fpu(fpu_a, fpu_b, fpu_op);
    p1 <= p0;
  end
  assign fpu_o = p1;

  function automatic logic [31:0] pat_a(input int i);
    return 32'(i + 1) << 24;
  endfunction
  function automatic logic [31:0] pat_b(input int i);
    return 32'(i + 1) * 32'h11;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_all();
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = pat_a(i);
      req_b[i*32 +: 32] = pat_b(i);
      req_op[i*2 +: 2]  = 2'(i);
    end
  endtask

  task automatic wait_hs(output int idx, output int at);
    bit found = 0;
    idx = -1;
    at  = -1;
    for (int k = 0; k < 20; k++) begin
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) idx = i;
        at = cyc;
        found = 1;
        tick();
        break;
      end
      tick();
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $error("FAIL hs_timeout: observed none expected handshake within 20 cycles");
    end
  endtask

  task automatic wait_rsp(input int hs_at, input int exp_id, input logic [31:0] exp_data,
                          input string tag);
    bit found = 0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin
        chk({tag, "_lat"}, 32'(cyc - hs_at), 32'd4);
        chk({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, "_data"}, rsp_data, exp_data);
        $display("[TB] %s: rsp id=%0d data=%h at cycle %0d", tag, rsp_id, rsp_data, cyc);
        found = 1;
        tick();
        break;
      end
      tick();
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_timeout: observed no rsp_valid expected one within 20 cycles", tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, at, prev, seen;
    int order [5] = '{0, 1, 2, 3, 0};

    reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    tick(); tick(); settle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_fpu_op", 32'(fpu_op), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);

    // Requester 0 ADD 1.0 + 2.0
    reset = 1'b0;
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000; req_op[1:0] = OP_ADD;
    req_valid = 4'b0001;
    settle();
    chk("add_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0100;
    settle();
    chk("add_exec_noaccept", 32'(req_ready), 32'h0);
    chk("add_busy", 32'(busy), 32'd1);
    chk("add_fpu_a", fpu_a, 32'h3F800000);
    chk("add_fpu_b", fpu_b, 32'h40000000);
    chk("add_fpu_op", 32'(fpu_op), 32'(OP_ADD));
    tick();
    chk("add_exec2_noaccept", 32'(req_ready), 32'h0);
    tick();
    chk("add_exec3_fpu_a", fpu_a, 32'h3F800000);
    chk("add_exec3_no_rsp", 32'(rsp_valid), 32'd0);
    req_valid = 4'b0000;
    tick();
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_id", 32'(rsp_id), 32'd0);
    chk("add_rsp_data", rsp_data, 32'h40400000);
    chk("add_resp_noaccept", 32'(req_ready), 32'h0);
    $display("[TB] add: rsp id=%0d data=%h", rsp_id, rsp_data);
    tick();
    chk("add_after_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("add_hold_data", rsp_data, 32'h40400000);
    chk("add_idle", 32'(busy), 32'd0);
    chk("add_ops_done", 32'(ops_done), 32'd1);

    // Requester 1 MUL 2.0 * 3.0
    req_a[63:32] = 32'h40000000; req_b[63:32] = 32'h40400000; req_op[3:2] = OP_MUL;
    req_valid = 4'b0010;
    settle();
    chk("mul_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    settle();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mul_fpu_a_t%0d", k + 1), fpu_a, 32'h40000000);
      chk($sformatf("mul_fpu_b_t%0d", k + 1), fpu_b, 32'h40400000);
      chk($sformatf("mul_fpu_op_t%0d", k + 1), 32'(fpu_op), 32'(OP_MUL));
      tick();
    end
    chk("mul_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("mul_rsp_id", 32'(rsp_id), 32'd1);
    chk("mul_rsp_data", rsp_data, 32'h40C00000);
    $display("[TB] mul: rsp id=%0d data=%h", rsp_id, rsp_data);
    tick();
    chk("mul_ops_done", 32'(ops_done), 32'd2);

    // All four requesting continuously from reset
    reset = 1'b1; set_all(); req_valid = 4'b1111;
    tick(); tick();
    reset = 1'b0;
    settle();
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_hs(idx, at);
      $display("[TB] rr: handshake %0d requester %0d at cycle %0d", k, idx, at);
      chk($sformatf("rr_grant%0d", k), 32'(idx), 32'(order[k]));
      if (k > 0) chk($sformatf("rr_spacing%0d", k), 32'(at - prev), 32'd5);
      prev = at;
      wait_rsp(at, order[k], fake_fpu(pat_a(order[k]), pat_b(order[k]), 2'(order[k])),
               $sformatf("rr%0d", k));
    end

    // Only requester 2
    reset = 1'b1; req_valid = 4'b0100;
    tick(); tick();
    reset = 1'b0;
    settle();
    for (int k = 0; k < 4; k++) begin
      wait_hs(idx, at);
      $display("[TB] solo: handshake requester %0d at cycle %0d", idx, at);
      chk($sformatf("solo_grant%0d", k), 32'(idx), 32'd2);
      if (k > 0) chk($sformatf("solo_spacing%0d", k), 32'(at - prev), 32'd5);
      prev = at;
      wait_rsp(at, 2, fake_fpu(pat_a(2), pat_b(2), 2'd2), $sformatf("solo%0d", k));
    end
    chk("solo_ops_done", 32'(ops_done), 32'd4);
    req_valid = 4'b0000;
    settle();

    // Reset pulsed in the second EXEC cycle
    req_valid = 4'b0001;
    settle();
    wait_hs(idx, at);
    req_valid = 4'b0000;
    tick();
    reset = 1'b1;
    settle();
    tick();
    reset = 1'b0; req_valid = 4'b1111;
    settle();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready0", 32'(req_ready), 32'h1);
    chk("abort_ops_done", 32'(ops_done), 32'd0);
    req_valid = 4'b0000;
    settle();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    $display("[TB] abort: rsp pulses after reset = %0d", seen);

    // Requester 3 drops while requester 0 stays high
    req_valid = 4'b0100;
    settle();
    wait_hs(idx, at);
    chk("drop_pre_grant", 32'(idx), 32'd2);
    req_valid = 4'b0000;
    wait_rsp(at, 2, fake_fpu(pat_a(2), pat_b(2), 2'd2), "drop_pre");
    req_valid = 4'b1001;
    settle();
    chk("drop_ready3", 32'(req_ready), 32'h8);
    req_valid = 4'b0001;
    settle();
    chk("drop_ready0", 32'(req_ready), 32'h1);
    at = cyc;
    tick();
    req_valid = 4'b0000;
    settle();
    chk("drop_fpu_a", fpu_a, pat_a(0));
    chk("drop_fpu_op", 32'(fpu_op), 32'd0);
    wait_rsp(at, 0, fake_fpu(pat_a(0), pat_b(0), 2'd0), "drop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
